timer_a_ccm: RTL and testbench

//  One Timer_A capture/compare channel: holds TAxCCTLn and TAxCCRn, compares TAR against

---
 rtl/timer_a_ccm.sv | 218 +++++++++++++++++++++
 tb/tb_timer_a_ccm.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_a_ccm.sv
// Timer_A capture/compare channel: TAxCCTLn/TAxCCRn registers, edge capture through an
// input synchroniser, TAR compare, OUTn output unit and CCIFG/COV flag handling.
module timer_a_ccm #(
    parameter int CCM_INDEX   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic        MCLK,
    input  logic        reset,
    input  logic        TAtick,
    input  logic [15:0] TAR,
    input  logic        EQU0,
    input  logic        CCIxA,
    input  logic        CCIxB,
    input  logic        CCTLwr,
    input  logic        CCRwr,
    input  logic [15:0] MDB_in,
    input  logic        CCIFGclr,
    output logic [15:0] CCTL,
    output logic [15:0] CCR,
    output logic        wCCIFG,
    output logic        wCCIE,
    output logic        EQU,
    output logic        OUTn
);

    typedef enum logic [2:0] {
        OM_BITS    = 3'd0,
        OM_SET     = 3'd1,
        OM_TOG_RST = 3'd2,
        OM_SET_RST = 3'd3,
        OM_TOG     = 3'd4,
        OM_RST     = 3'd5,
        OM_TOG_SET = 3'd6,
        OM_RST_SET = 3'd7
    } outmod_e;

    logic [1:0]             cm_q, cm_d;
    logic [1:0]             ccis_sel_q, ccis_sel_d;
    logic                   scs_q, scs_d;
    logic                   scci_q, scci_d;
    logic                   cap_q, cap_d;
    outmod_e                outmod_q, outmod_d;
    logic                   ccie_q, ccie_d;
    logic                   out_q, out_d;
    logic                   cov_q, cov_d;
    logic                   ccifg_q, ccifg_d;
    logic [15:0]            ccr_q, ccr_d;
    logic                   pending_q, pending_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ccis_prev_q;

    logic cci_src;
    logic ccis;
    logic rise;
    logic fall;
    logic edge_hit;
    logic cfg_change;
    logic capture;
    logic equ;
    logic equ0;
    logic hw_set;
    logic out_hit;
    logic out_hw;
    logic unused_bits;

    // Read-only CCTL bits are never loaded; channel 0 derives EQU0 from its own compare.
    assign unused_bits = ^{MDB_in[10:9], MDB_in[3], EQU0};

    always_comb begin
        case (ccis_sel_q)
            2'd0:    cci_src = CCIxA;
            2'd1:    cci_src = CCIxB;
            2'd2:    cci_src = 1'b0;
            default: cci_src = 1'b1;
        endcase
    end

    assign ccis = sync_q[SYNC_STAGES-1];
    assign rise = ccis & ~ccis_prev_q;
    assign fall = ~ccis & ccis_prev_q;

    always_comb begin
        case (cm_q)
            2'd0:    edge_hit = 1'b0;
            2'd1:    edge_hit = rise;
            2'd2:    edge_hit = fall;
            default: edge_hit = rise | fall;
        endcase
    end

    // Switching mode or input source discards any capture still waiting for a tick.
    assign cfg_change = CCTLwr & ((MDB_in[8] != cap_q) | (MDB_in[13:12] != ccis_sel_q));
    assign capture    = cap_q & ((edge_hit & ~scs_q) | (pending_q & TAtick));
    assign equ        = ~reset & ~cap_q & TAtick & (TAR == ccr_q);
    assign equ0       = (CCM_INDEX == 0) ? equ : EQU0;
    assign hw_set     = capture | equ;

    // EQU is tested first in every mode, so it wins when both compare pulses coincide.
    always_comb begin
        out_hit = 1'b0;
        out_hw  = out_q;
        case (outmod_q)
            OM_SET: begin
                if (equ) begin out_hit = 1'b1; out_hw = 1'b1; end
            end
            OM_TOG_RST: begin
                if (equ)       begin out_hit = 1'b1; out_hw = ~out_q; end
                else if (equ0) begin out_hit = 1'b1; out_hw = 1'b0;   end
            end
            OM_SET_RST: begin
                if (equ)       begin out_hit = 1'b1; out_hw = 1'b1; end
                else if (equ0) begin out_hit = 1'b1; out_hw = 1'b0; end
            end
            OM_TOG: begin
                if (equ) begin out_hit = 1'b1; out_hw = ~out_q; end
            end
            OM_RST: begin
                if (equ) begin out_hit = 1'b1; out_hw = 1'b0; end
            end
            OM_TOG_SET: begin
                if (equ)       begin out_hit = 1'b1; out_hw = ~out_q; end
                else if (equ0) begin out_hit = 1'b1; out_hw = 1'b1;   end
            end
            OM_RST_SET: begin
                if (equ)       begin out_hit = 1'b1; out_hw = 1'b0; end
                else if (equ0) begin out_hit = 1'b1; out_hw = 1'b1; end
            end
            default: ;
        endcase
    end

    // NOTE: later assignments override earlier ones, which encodes hw set > clear > bus write.
    always_comb begin
        cm_d       = cm_q;
        ccis_sel_d = ccis_sel_q;
        scs_d      = scs_q;
        scci_d     = scci_q;
        cap_d      = cap_q;
        outmod_d   = outmod_q;
        ccie_d     = ccie_q;
        out_d      = out_q;
        cov_d      = cov_q;
        ccifg_d    = ccifg_q;
        ccr_d      = ccr_q;
        pending_d  = pending_q;

        if (CCTLwr) begin
            cm_d       = MDB_in[15:14];
            ccis_sel_d = MDB_in[13:12];
            scs_d      = MDB_in[11];
            cap_d      = MDB_in[8];
            outmod_d   = outmod_e'(MDB_in[7:5]);
            ccie_d     = MDB_in[4];
            out_d      = MDB_in[2];
            cov_d      = MDB_in[1];
            ccifg_d    = MDB_in[0];
        end
        if (CCIFGclr) ccifg_d = 1'b0;
        if (hw_set) begin
            ccifg_d = 1'b1;
            scci_d  = ccis;
        end
        if (capture & ccifg_q) cov_d = 1'b1;
        if (out_hit) out_d = out_hw;

        if (capture)    ccr_d = TAR;
        else if (CCRwr) ccr_d = MDB_in;

        if (pending_q & TAtick)         pending_d = 1'b0;
        if (cap_q & scs_q & edge_hit)   pending_d = 1'b1;
        if (cfg_change)                 pending_d = 1'b0;
    end

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            cm_d_reset_block: begin
                cm_q        <= 2'd0;
                ccis_sel_q  <= 2'd0;
                scs_q       <= 1'b0;
                scci_q      <= 1'b0;
                cap_q       <= 1'b0;
                outmod_q    <= OM_BITS;
                ccie_q      <= 1'b0;
                out_q       <= 1'b0;
                cov_q       <= 1'b0;
                ccifg_q     <= 1'b0;
                ccr_q       <= 16'h0000;
                pending_q   <= 1'b0;
                sync_q      <= '0;
                ccis_prev_q <= 1'b0;
            end
        end else begin
            cm_q        <= cm_d;
            ccis_sel_q  <= ccis_sel_d;
            scs_q       <= scs_d;
            scci_q      <= scci_d;
            cap_q       <= cap_d;
            outmod_q    <= outmod_d;
            ccie_q      <= ccie_d;
            out_q       <= out_d;
            cov_q       <= cov_d;
            ccifg_q     <= ccifg_d;
            ccr_q       <= ccr_d;
            pending_q   <= pending_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], cci_src};
            ccis_prev_q <= ccis;
        end
    end

    assign CCTL   = {cm_q, ccis_sel_q, scs_q, scci_q, 1'b0, cap_q, outmod_q,
                     ccie_q, ccis, out_q, cov_q, ccifg_q};
    assign CCR    = ccr_q;
    assign wCCIFG = ccifg_q;
    assign wCCIE  = ccie_q;
    assign EQU    = equ;
    assign OUTn   = out_q;

endmodule

// File: tb/tb_timer_a_ccm.sv
// Self-checking bench for timer_a_ccm: directed scenarios plus randomized traffic against
// a cycle-level reference model of the channel's register and flag rules.
module tb_timer_a_ccm;

    localparam int S = 2;

    logic        MCLK = 1'b0;
    logic        reset = 1'b0;
    logic        TAtick = 1'b0;
    logic [15:0] TAR = 16'h0;
    logic        EQU0 = 1'b0;
    logic        CCIxA = 1'b0;
    logic        CCIxB = 1'b0;
    logic        CCTLwr = 1'b0;
    logic        CCRwr = 1'b0;
    logic [15:0] MDB_in = 16'h0;
    logic        CCIFGclr = 1'b0;
    logic [15:0] CCTL;
    logic [15:0] CCR;
    logic        wCCIFG;
    logic        wCCIE;
    logic        EQU;
    logic        OUTn;

    int errors = 0;
    int checks = 0;

    timer_a_ccm #(.CCM_INDEX(1), .SYNC_STAGES(S)) dut (
        .MCLK(MCLK), .reset(reset), .TAtick(TAtick), .TAR(TAR), .EQU0(EQU0),
        .CCIxA(CCIxA), .CCIxB(CCIxB), .CCTLwr(CCTLwr), .CCRwr(CCRwr), .MDB_in(MDB_in),
        .CCIFGclr(CCIFGclr), .CCTL(CCTL), .CCR(CCR), .wCCIFG(wCCIFG), .wCCIE(wCCIE),
        .EQU(EQU), .OUTn(OUTn)
    );

    always #5 MCLK = ~MCLK;

    // Reference model: register fields as plain values, synchroniser as a history queue.
    typedef struct {
        logic [1:0]  cm;
        logic [1:0]  sel;
        logic        scs;
        logic        scci;
        logic        cap;
        logic [2:0]  om;
        logic        ccie;
        logic        out;
        logic        cov;
        logic        ifg;
        logic        pend;
        logic [15:0] ccr;
    } model_t;

    // Output-unit actions per mode: 0 none, 1 set, 2 reset, 3 toggle.
    localparam int EQU_ACT [8] = '{0, 1, 3, 1, 3, 2, 3, 2};
    localparam int E0_ACT  [8] = '{0, 0, 2, 2, 0, 0, 1, 1};

    model_t m;
    model_t nx;
    logic   hist[$];
    logic   nx_src;
    logic   nx_rst;
    logic   exp_equ;
    logic   seen_equ;

    task automatic model_clear();
        m.cm = 0; m.sel = 0; m.scs = 0; m.scci = 0; m.cap = 0; m.om = 0;
        m.ccie = 0; m.out = 0; m.cov = 0; m.ifg = 0; m.pend = 0; m.ccr = 0;
        hist.delete();
        for (int i = 0; i <= S; i++) hist.push_back(1'b0);
    endtask

    function automatic logic [15:0] model_cctl();
        return {m.cm, m.sel, m.scs, m.scci, 1'b0, m.cap, m.om, m.ccie, hist[S-1],
                m.out, m.cov, m.ifg};
    endfunction

    task automatic model_eval();
        logic ccis, prev, qual, equ, grab, chg;
        int   act;
        nx = m;
        nx_rst = reset;
        nx_src = (m.sel == 0) ? CCIxA : (m.sel == 1) ? CCIxB : (m.sel == 3);
        ccis = hist[S-1];
        prev = hist[S];
        qual = (m.cm[0] && ccis && !prev) || (m.cm[1] && !ccis && prev);
        equ  = !reset && !m.cap && TAtick && (TAR == m.ccr);
        grab = m.cap && ((qual && !m.scs) || (m.pend && TAtick));
        chg  = CCTLwr && (MDB_in[8] != m.cap || MDB_in[13:12] != m.sel);
        exp_equ = equ;
        act = equ ? EQU_ACT[m.om] : (EQU0 ? E0_ACT[m.om] : 0);

        if (CCTLwr) begin
            nx.cm = MDB_in[15:14]; nx.sel = MDB_in[13:12]; nx.scs = MDB_in[11];
            nx.cap = MDB_in[8]; nx.om = MDB_in[7:5]; nx.ccie = MDB_in[4];
        end
        nx.ifg  = (grab || equ) ? 1'b1 : CCIFGclr ? 1'b0 : CCTLwr ? MDB_in[0] : m.ifg;
        nx.cov  = (grab && m.ifg) ? 1'b1 : CCTLwr ? MDB_in[1] : m.cov;
        nx.scci = (grab || equ) ? ccis : m.scci;
        nx.out  = (act == 1) ? 1'b1 : (act == 2) ? 1'b0 : (act == 3) ? !m.out :
                  CCTLwr ? MDB_in[2] : m.out;
        nx.ccr  = grab ? TAR : CCRwr ? MDB_in : m.ccr;
        if (chg)                           nx.pend = 1'b0;
        else if (m.cap && m.scs && qual)   nx.pend = 1'b1;
        else if (TAtick)                   nx.pend = 1'b0;
    endtask

    // One MCLK: evaluate model mid-cycle, sample EQU there, commit both after the edge.
    task automatic step();
        @(negedge MCLK);
        model_eval();
        seen_equ = EQU;
        @(posedge MCLK);
        #1;
        if (nx_rst) begin
            model_clear();
        end else begin
            m = nx;
            hist.push_front(nx_src);
            void'(hist.pop_back());
        end
    endtask

    task automatic idle_inputs();
        TAtick = 0; TAR = 0; EQU0 = 0; CCIxA = 0; CCIxB = 0;
        CCTLwr = 0; CCRwr = 0; MDB_in = 0; CCIFGclr = 0;
    endtask

    task automatic apply_reset();
        @(posedge MCLK);
        #1;
        idle_inputs();
        reset = 1'b1;
        model_clear();
        step();
        reset = 1'b0;
    endtask

    task automatic write_cctl(input logic [15:0] v);
        CCTLwr = 1; MDB_in = v; step(); CCTLwr = 0;
    endtask

    task automatic write_ccr(input logic [15:0] v);
        CCRwr = 1; MDB_in = v; step(); CCRwr = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (CCTL !== 16'h0) begin errors++; $display("FAIL reset_cctl: got %h want 0000", CCTL); end
        checks++; if (CCR !== 16'h0) begin errors++; $display("FAIL reset_ccr: got %h want 0000", CCR); end
        checks++; if ({EQU, OUTn, wCCIFG, wCCIE} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {EQU, OUTn, wCCIFG, wCCIE}); end
    endtask

    task automatic test_compare();
        apply_reset();
        write_ccr(16'h0005);
        write_cctl(16'h0060);
        for (int t = 0; t <= 5; t++) begin
            TAR = 16'(t); TAtick = 1; step();
            checks++; if (seen_equ !== (t == 5)) begin errors++; $display("FAIL cmp_equ tar=%0d: got %b want %b", t, seen_equ, (t == 5)); end
        end
        TAtick = 0;
        checks++; if ({wCCIFG, OUTn} !== 2'b11) begin errors++; $display("FAIL cmp_flag_out: got %b want 11", {wCCIFG, OUTn}); end
        EQU0 = 1; step(); EQU0 = 0;
        checks++; if ({wCCIFG, OUTn, CCTL[2]} !== 3'b100) begin errors++; $display("FAIL cmp_equ0_reset: got %b want 100", {wCCIFG, OUTn, CCTL[2]}); end
    endtask

    task automatic test_capture();
        apply_reset();
        write_cctl(16'h4100);
        TAR = 16'h1234; CCIxA = 1;
        step(); step();
        checks++; if (wCCIFG !== 1'b0) begin errors++; $display("FAIL cap_early: got %b want 0", wCCIFG); end
        step();
        checks++; if (CCR !== 16'h1234) begin errors++; $display("FAIL cap_ccr: got %h want 1234", CCR); end
        checks++; if ({wCCIFG, CCTL[1], CCTL[10], CCTL[3]} !== 4'b1011) begin errors++; $display("FAIL cap_bits ifg/cov/scci/cci: got %b want 1011", {wCCIFG, CCTL[1], CCTL[10], CCTL[3]}); end
    endtask

    task automatic test_overflow();
        CCIxA = 0;
        repeat (3) step();
        checks++; if (CCR !== 16'h1234) begin errors++; $display("FAIL ovf_fall_ignored: got %h want 1234", CCR); end
        TAR = 16'h2000; CCIxA = 1;
        repeat (3) step();
        checks++; if ({CCR, wCCIFG, CCTL[1]} !== {16'h2000, 2'b11}) begin errors++; $display("FAIL ovf_capture ccr/ifg/cov: got %h %b%b want 2000 11", CCR, wCCIFG, CCTL[1]); end
        CCIFGclr = 1; step(); CCIFGclr = 0;
        checks++; if ({wCCIFG, CCTL[1]} !== 2'b01) begin errors++; $display("FAIL ovf_clear ifg/cov: got %b want 01", {wCCIFG, CCTL[1]}); end
    endtask

    task automatic test_sync_capture();
        apply_reset();
        write_cctl(16'h4900);
        TAR = 16'h0100; CCIxA = 1;
        repeat (6) step();
        checks++; if ({CCR, wCCIFG} !== {16'h0000, 1'b0}) begin errors++; $display("FAIL scs_wait: got %h %b want 0000 0", CCR, wCCIFG); end
        TAR = 16'h0101; TAtick = 1; step();
        checks++; if ({CCR, wCCIFG} !== {16'h0101, 1'b1}) begin errors++; $display("FAIL scs_tick: got %h %b want 0101 1", CCR, wCCIFG); end
        TAR = 16'h0102; step(); TAtick = 0;
        checks++; if (CCR !== 16'h0101) begin errors++; $display("FAIL scs_once: got %h want 0101", CCR); end
    endtask

    task automatic test_collision();
        apply_reset();
        write_ccr(16'h0007);
        TAR = 16'h0007; TAtick = 1; CCIFGclr = 1; step(); TAtick = 0;
        checks++; if ({seen_equ, wCCIFG} !== 2'b11) begin errors++; $display("FAIL col_set_vs_clr: got %b want 11", {seen_equ, wCCIFG}); end
        CCTLwr = 1; MDB_in = 16'h0001; step(); CCIFGclr = 0;
        checks++; if (wCCIFG !== 1'b0) begin errors++; $display("FAIL col_clr_vs_write: got %b want 0", wCCIFG); end
        step(); CCTLwr = 0;
        checks++; if (wCCIFG !== 1'b1) begin errors++; $display("FAIL col_write_set: got %b want 1", wCCIFG); end
        write_cctl(16'h4100);
        TAR = 16'h3333; CCIxA = 1;
        step(); step();
        write_ccr(16'hBEEF);
        checks++; if (CCR !== 16'h3333) begin errors++; $display("FAIL col_ccrwr_vs_capture: got %h want 3333", CCR); end
    endtask

    task automatic test_reset_midcapture();
        apply_reset();
        write_ccr(16'h0003);
        write_cctl(16'h0020);
        TAR = 16'h0003; TAtick = 1; step(); TAtick = 0;
        write_cctl(16'h4924);
        CCIxA = 1;
        repeat (4) step();
        checks++; if ({CCR, OUTn} !== {16'h0003, 1'b1}) begin errors++; $display("FAIL rst_pre: got %h %b want 0003 1", CCR, OUTn); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({CCTL, CCR} !== 32'h0) begin errors++; $display("FAIL rst_async_regs: got %h %h want 0000 0000", CCTL, CCR); end
        checks++; if ({EQU, OUTn, wCCIFG, wCCIE} !== 4'b0) begin errors++; $display("FAIL rst_async_flags: got %b want 0000", {EQU, OUTn, wCCIFG, wCCIE}); end
        model_clear();
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            TAR = 16'h4444 + 16'(i); TAtick = 1; step();
        end
        TAtick = 0;
        checks++; if ({CCR, wCCIFG} !== {16'h0000, 1'b0}) begin errors++; $display("FAIL rst_no_capture: got %h %b want 0000 0", CCR, wCCIFG); end
    endtask

    task automatic test_random();
        logic [15:0] tar_cnt;
        apply_reset();
        tar_cnt = 0;
        for (int n = 0; n < 600; n++) begin
            TAtick   = ($urandom_range(0, 2) == 0);
            if (TAtick) tar_cnt = (tar_cnt >= 11) ? 16'h0 : tar_cnt + 1;
            if ($urandom_range(0, 30) == 0) tar_cnt = 16'($urandom_range(0, 11));
            TAR      = tar_cnt;
            EQU0     = ($urandom_range(0, 9) == 0);
            CCIFGclr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0) CCIxA = ~CCIxA;
            if ($urandom_range(0, 5) == 0) CCIxB = ~CCIxB;
            CCTLwr   = ($urandom_range(0, 15) == 0);
            CCRwr    = ($urandom_range(0, 15) == 0);
            MDB_in   = CCTLwr ? 16'($urandom) : 16'($urandom_range(0, 11));
            step();
            checks++; if (seen_equ !== exp_equ) begin errors++; $display("FAIL rnd_equ n=%0d: got %b want %b", n, seen_equ, exp_equ); end
            checks++; if (CCTL !== model_cctl()) begin errors++; $display("FAIL rnd_cctl n=%0d: got %h want %h", n, CCTL, model_cctl()); end
            checks++; if (CCR !== m.ccr) begin errors++; $display("FAIL rnd_ccr n=%0d: got %h want %h", n, CCR, m.ccr); end
            checks++; if ({OUTn, wCCIFG, wCCIE} !== {m.out, m.ifg, m.ccie}) begin errors++; $display("FAIL rnd_outs n=%0d: got %b want %b", n, {OUTn, wCCIFG, wCCIE}, {m.out, m.ifg, m.ccie}); end
        end
        idle_inputs();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_compare();
        test_capture();
        test_overflow();
        test_sync_capture();
        test_collision();
        test_reset_midcapture();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
